// File: rtl/pi_digit_reader.sv
// Serialises the pi limb vector (base-1000 limbs, integer limb on top) into
// 4-bit BCD digits over valid/ready. Optional decimal-point code: PI_DOT_EN.
module pi_digit_reader #(
  parameter int L  = 47,
  parameter int N  = 10,
  parameter int PW = 9
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [L*N-1:0] sum,
  output logic           busy,
  output logic [3:0]     digit,
  output logic           digit_valid,
  input  logic           digit_ready,
  output logic           digit_last,
  output logic [PW-1:0]  digit_pos,
  output logic           range_err
);

  localparam int LIW = (L > 1) ? $clog2(L) : 1;
  localparam logic [LIW-1:0] LI_TOP = LIW'(L - 1);

  typedef enum logic [2:0] {
    IDLE, CONV_H, CONV_T, EMIT_H, EMIT_T, EMIT_U
`ifdef PI_DOT_EN
    , EMIT_DP
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [L*N-1:0] shadow_q, shadow_d;
  logic [LIW-1:0] li_q, li_d;
  logic [9:0]     r_q, r_d;
  logic [3:0]     h_q, h_d, t_q, t_d;
  logic [PW-1:0]  pos_q, pos_d;
  logic           err_q, err_d;

  // Limb loader: from IDLE the integer limb comes straight off the bus,
  // otherwise the next lower limb comes from the shadow copy.
  logic [L*N-1:0] ld_src;
  logic [LIW-1:0] li_ld;
  logic [N-1:0]   ld_limb;
  logic [9:0]     ld_r;
  logic           ld_err;

  always_comb begin
    ld_src  = (state_q == IDLE) ? sum : shadow_q;
    li_ld   = (state_q == IDLE) ? LI_TOP : li_q - 1'b1;
    ld_limb = ld_src[int'(li_ld)*N +: N];
    ld_err  = 1'b0;
    ld_r    = 10'd999;
    if (32'(ld_limb) > 32'd999) ld_err = 1'b1;
    else                        ld_r   = 10'(ld_limb);
    if ((li_ld == LI_TOP) && (ld_r > 10'd9)) begin
      ld_r   = 10'd9;
      ld_err = 1'b1;
    end
  end

  always_comb begin
    busy        = (state_q != IDLE);
    digit_valid = 1'b0;
    digit       = 4'd0;
    case (state_q)
      EMIT_H:  begin digit_valid = 1'b1; digit = h_q;      end
      EMIT_T:  begin digit_valid = 1'b1; digit = t_q;      end
      EMIT_U:  begin digit_valid = 1'b1; digit = r_q[3:0]; end
`ifdef PI_DOT_EN
      EMIT_DP: begin digit_valid = 1'b1; digit = 4'hA;     end
`endif
      default: ;
    endcase
    digit_last = (state_q == EMIT_U) && (li_q == '0);
    digit_pos  = pos_q;
    range_err  = err_q;
  end

  logic xfer, nxt;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    li_d     = li_q;
    r_d      = r_q;
    h_d      = h_q;
    t_d      = t_q;
    pos_d    = pos_q;
    err_d    = err_q;
    nxt      = 1'b0;
    xfer     = digit_valid && digit_ready;
    if (xfer) pos_d = pos_q + 1'b1;
    case (state_q)
      IDLE: if (start) begin
        shadow_d = sum;
        li_d     = LI_TOP;
        r_d      = ld_r;
        h_d      = 4'd0;
        t_d      = 4'd0;
        pos_d    = '0;
        err_d    = ld_err;
        state_d  = CONV_H;
      end
      CONV_H: if (r_q >= 10'd100) begin
        r_d = r_q - 10'd100;
        h_d = h_q + 4'd1;
      end else state_d = CONV_T;
      CONV_T: if (r_q >= 10'd10) begin
        r_d = r_q - 10'd10;
        t_d = t_q + 4'd1;
      end else state_d = (li_q == LI_TOP) ? EMIT_U : EMIT_H;
      EMIT_H: if (xfer) state_d = EMIT_T;
      EMIT_T: if (xfer) state_d = EMIT_U;
      EMIT_U: if (xfer) begin
        if (li_q == '0) state_d = IDLE;
`ifdef PI_DOT_EN
        else if (li_q == LI_TOP) state_d = EMIT_DP;
`endif
        else nxt = 1'b1;
      end
`ifdef PI_DOT_EN
      EMIT_DP: if (xfer) nxt = 1'b1;
`endif
      default: state_d = IDLE;
    endcase
    if (nxt) begin
      li_d    = li_q - 1'b1;
      r_d     = ld_r;
      h_d     = 4'd0;
      t_d     = 4'd0;
      err_d   = err_q | ld_err;
      state_d = CONV_H;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      li_q     <= '0;
      r_q      <= '0;
      h_q      <= '0;
      t_q      <= '0;
      pos_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      li_q     <= li_d;
      r_q      <= r_d;
      h_q      <= h_d;
      t_q      <= t_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_pi_digit_reader.sv
// Directed bench for pi_digit_reader: stream content, timing, backpressure,
// range clamping, start-while-busy and mid-stream reset.
module tb_pi_digit_reader;
  localparam int L = 47, N = 10, PW = 9;
`ifdef PI_DOT_EN
  localparam int DOT = 1;
`else
  localparam int DOT = 0;
`endif
  localparam int SLEN   = 1 + 3*(L-1) + DOT;
  localparam int PI_CYC = 263 + DOT;

  logic           clk = 1'b0;
  logic           rst, start, digit_ready;
  logic [L*N-1:0] sum;
  logic           busy, digit_valid, digit_last, range_err;
  logic [3:0]     digit;
  logic [PW-1:0]  digit_pos;

  pi_digit_reader #(.L(L), .N(N), .PW(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .sum(sum), .busy(busy),
    .digit(digit), .digit_valid(digit_valid), .digit_ready(digit_ready),
    .digit_last(digit_last), .digit_pos(digit_pos), .range_err(range_err)
  );

  always #5 clk = ~clk;

  int cmp_n = 0, bad_n = 0;
  int got_dig [0:255];
  int got_pos [0:255];
  bit got_last[0:255];
  int n_got, first_lat, last_cyc, hold_bad;
  bit done, aborted, timed_out, busy_at1, err_at1, busy_after, valid_after;
  logic s_busy, s_valid, s_last, s_err;
  logic [3:0] s_digit;
  logic [PW-1:0] s_pos;

  function automatic int exp_pi(input int p);
    int pd[10] = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    int f;
    if (DOT == 1 && p == 1) return 10;
    f = (DOT == 1 && p > 1) ? p - 1 : p;
    return (f < 10) ? pd[f] : 0;
  endfunction

  function automatic int exp_rng(input int p);
    int f;
    if (DOT == 1 && p == 1) return 10;
    f = (DOT == 1 && p > 1) ? p - 1 : p;
    return (f < 4) ? 9 : 0;
  endfunction

  function automatic logic [L*N-1:0] mk_vec(input int a46, input int a45,
                                             input int a44, input int a43);
    logic [L*N-1:0] v;
    v = '0;
    v[N*46 +: N] = N'(a46);
    v[N*45 +: N] = N'(a45);
    v[N*44 +: N] = N'(a44);
    v[N*43 +: N] = N'(a43);
    return v;
  endfunction

  // Starts a stream and collects transfers; optional hold, start glitch,
  // reset abort and a start pulse on the final transfer cycle.
  task automatic run_stream(input logic [L*N-1:0] vec, input logic [L*N-1:0] alt,
                            input int hold_pos, input int glitch_pos,
                            input int rst_pos, input bit start_at_last);
    int cyc, hold_left, hd, hp;
    bit glitched, hold_fin;
    n_got = 0; first_lat = -1; last_cyc = -1; hold_bad = 0;
    done = 0; aborted = 0; glitched = 0; hold_fin = 0; hold_left = 5;
    hd = 0; hp = 0;
    @(negedge clk); sum = vec; start = 1'b1; digit_ready = 1'b1;
    @(negedge clk); start = 1'b0; sum = ~vec;
    busy_at1 = busy; err_at1 = range_err;
    cyc = 1;
    while (!done && !aborted && cyc < 3000) begin
      start = 1'b0; digit_ready = 1'b1;
      if (digit_valid && first_lat < 0) first_lat = cyc;
      if (rst_pos >= 0 && digit_valid && int'(digit_pos) == rst_pos) begin
        rst = 1'b0; #1;
        s_busy = busy; s_valid = digit_valid; s_last = digit_last;
        s_err = range_err; s_digit = digit; s_pos = digit_pos;
        aborted = 1;
      end else begin
        if (glitch_pos >= 0 && !glitched && digit_valid && int'(digit_pos) == glitch_pos) begin
          sum = alt; start = 1'b1; glitched = 1;
        end
        if (hold_pos >= 0 && !hold_fin) begin
          if (hold_left == 5) begin
            if (digit_valid && int'(digit_pos) == hold_pos) begin
              hd = digit; hp = digit_pos; digit_ready = 1'b0; hold_left = 4;
            end
          end else begin
            if (digit_valid !== 1'b1 || int'(digit) != hd || int'(digit_pos) != hp) hold_bad++;
            if (hold_left > 0) begin digit_ready = 1'b0; hold_left--; end
            else hold_fin = 1;
          end
        end
        if (digit_valid && digit_ready) begin
          if (n_got < 256) begin
            got_dig[n_got] = digit; got_pos[n_got] = digit_pos; got_last[n_got] = digit_last;
          end
          n_got++;
          if (digit_last) begin
            done = 1; last_cyc = cyc;
            if (start_at_last) begin sum = vec; start = 1'b1; end
          end
        end
        @(negedge clk); cyc++;
      end
    end
    timed_out = !done && !aborted;
    if (done) begin busy_after = busy; valid_after = digit_valid; end
    start = 1'b0; digit_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; digit_ready = 1'b0; sum = '0;
    #2;
    cmp_n++; if (busy !== 1'b0) begin bad_n++; $display("FAIL reset_busy: got %b want 0", busy); end
    cmp_n++; if (digit_valid !== 1'b0) begin bad_n++; $display("FAIL reset_valid: got %b want 0", digit_valid); end
    cmp_n++; if (digit !== 4'd0) begin bad_n++; $display("FAIL reset_digit: got %0d want 0", digit); end
    cmp_n++; if (digit_pos !== '0) begin bad_n++; $display("FAIL reset_pos: got %0d want 0", digit_pos); end
    cmp_n++; if (digit_last !== 1'b0) begin bad_n++; $display("FAIL reset_last: got %b want 0", digit_last); end
    cmp_n++; if (range_err !== 1'b0) begin bad_n++; $display("FAIL reset_err: got %b want 0", range_err); end
    @(negedge clk); rst = 1'b1; digit_ready = 1'b1;
    @(negedge clk);
    cmp_n++; if (busy !== 1'b0) begin bad_n++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic_stream();
    int nl;
    run_stream(mk_vec(3, 141, 592, 653), '0, -1, -1, -1, 1'b1);
    cmp_n++; if (timed_out) begin bad_n++; $display("FAIL basic_timeout: got %0d digits want %0d", n_got, SLEN); end
    cmp_n++; if (busy_at1 !== 1'b1) begin bad_n++; $display("FAIL basic_busy_rise: got %b want 1", busy_at1); end
    cmp_n++; if (err_at1 !== 1'b0) begin bad_n++; $display("FAIL basic_err: got %b want 0", err_at1); end
    cmp_n++; if (first_lat != 3) begin bad_n++; $display("FAIL basic_first_latency: got %0d want 3", first_lat); end
    cmp_n++; if (n_got != SLEN) begin bad_n++; $display("FAIL basic_count: got %0d want %0d", n_got, SLEN); end
    cmp_n++; if (last_cyc != PI_CYC) begin bad_n++; $display("FAIL basic_total_cycles: got %0d want %0d", last_cyc, PI_CYC); end
    nl = 0;
    for (int i = 0; i < n_got && i < SLEN; i++) begin
      cmp_n++;
      if (got_dig[i] != exp_pi(i) || got_pos[i] != i) begin
        bad_n++; $display("FAIL basic_digit[%0d]: got %0d@%0d want %0d@%0d", i, got_dig[i], got_pos[i], exp_pi(i), i);
      end
      if (got_last[i]) nl++;
    end
    cmp_n++; if (nl != 1 || got_last[SLEN-1] !== 1'b1) begin bad_n++; $display("FAIL basic_last: got %0d lasts want 1 at pos %0d", nl, SLEN-1); end
    cmp_n++; if (busy_after !== 1'b0 || valid_after !== 1'b0) begin bad_n++; $display("FAIL basic_busy_fall: got busy %b valid %b want 0 0", busy_after, valid_after); end
    @(negedge clk);
    cmp_n++; if (busy !== 1'b0) begin bad_n++; $display("FAIL start_on_fall_ignored: got busy %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    run_stream(mk_vec(3, 141, 592, 653), '0, 2, -1, -1, 1'b0);
    cmp_n++; if (timed_out) begin bad_n++; $display("FAIL bp_timeout: got %0d digits want %0d", n_got, SLEN); end
    cmp_n++; if (hold_bad != 0) begin bad_n++; $display("FAIL bp_hold_stable: got %0d unstable cycles want 0", hold_bad); end
    cmp_n++; if (n_got != SLEN) begin bad_n++; $display("FAIL bp_count: got %0d want %0d", n_got, SLEN); end
    cmp_n++; if (got_dig[3] != exp_pi(3)) begin bad_n++; $display("FAIL bp_pos3: got %0d want %0d", got_dig[3], exp_pi(3)); end
    for (int i = 0; i < n_got && i < SLEN; i++) begin
      cmp_n++;
      if (got_dig[i] != exp_pi(i) || got_pos[i] != i) begin
        bad_n++; $display("FAIL bp_digit[%0d]: got %0d@%0d want %0d@%0d", i, got_dig[i], got_pos[i], exp_pi(i), i);
      end
    end
  endtask

  task automatic test_range();
    run_stream(mk_vec(12, 1000, 0, 0), '0, -1, -1, -1, 1'b0);
    cmp_n++; if (timed_out) begin bad_n++; $display("FAIL rng_timeout: got %0d digits want %0d", n_got, SLEN); end
    cmp_n++; if (err_at1 !== 1'b1) begin bad_n++; $display("FAIL rng_err_set: got %b want 1", err_at1); end
    for (int i = 0; i < 8 && i < n_got; i++) begin
      cmp_n++;
      if (got_dig[i] != exp_rng(i)) begin
        bad_n++; $display("FAIL rng_digit[%0d]: got %0d want %0d", i, got_dig[i], exp_rng(i));
      end
    end
    repeat (3) @(negedge clk);
    cmp_n++; if (range_err !== 1'b1) begin bad_n++; $display("FAIL rng_err_sticky: got %b want 1", range_err); end
  endtask

  task automatic test_start_ignored();
    run_stream(mk_vec(3, 141, 592, 653), mk_vec(12, 1000, 999, 7), -1, 10, -1, 1'b0);
    cmp_n++; if (err_at1 !== 1'b0) begin bad_n++; $display("FAIL si_err_cleared: got %b want 0", err_at1); end
    cmp_n++; if (timed_out || n_got != SLEN) begin bad_n++; $display("FAIL si_count: got %0d want %0d", n_got, SLEN); end
    for (int i = 0; i < n_got && i < SLEN; i++) begin
      cmp_n++;
      if (got_dig[i] != exp_pi(i) || got_pos[i] != i) begin
        bad_n++; $display("FAIL si_digit[%0d]: got %0d@%0d want %0d@%0d", i, got_dig[i], got_pos[i], exp_pi(i), i);
      end
    end
    cmp_n++; if (range_err !== 1'b0) begin bad_n++; $display("FAIL si_err_end: got %b want 0", range_err); end
  endtask

  task automatic test_reset_mid();
    int nv;
    run_stream(mk_vec(3, 141, 592, 653), '0, -1, -1, 20, 1'b0);
    cmp_n++; if (!aborted) begin bad_n++; $display("FAIL rm_reached_pos20: got %0d digits want abort", n_got); end
    cmp_n++;
    if (s_busy !== 1'b0 || s_valid !== 1'b0 || s_last !== 1'b0 || s_err !== 1'b0 || s_digit !== 4'd0 || s_pos !== '0) begin
      bad_n++; $display("FAIL rm_outputs_zero: got busy %b valid %b last %b err %b digit %0d pos %0d want all 0",
                        s_busy, s_valid, s_last, s_err, s_digit, s_pos);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nv = 0;
    repeat (6) begin @(negedge clk); if (digit_valid !== 1'b0 || busy !== 1'b0) nv++; end
    cmp_n++; if (nv != 0) begin bad_n++; $display("FAIL rm_quiet_after_reset: got %0d active cycles want 0", nv); end
    run_stream(mk_vec(3, 141, 592, 653), '0, -1, -1, -1, 1'b0);
    cmp_n++; if (first_lat != 3) begin bad_n++; $display("FAIL rm_restart_latency: got %0d want 3", first_lat); end
    cmp_n++; if (timed_out || n_got != SLEN) begin bad_n++; $display("FAIL rm_restart_count: got %0d want %0d", n_got, SLEN); end
    cmp_n++; if (got_pos[0] != 0 || got_dig[0] != 3) begin bad_n++; $display("FAIL rm_restart_first: got %0d@%0d want 3@0", got_dig[0], got_pos[0]); end
    cmp_n++; if (got_dig[SLEN-1] != 0 || got_last[SLEN-1] !== 1'b1) begin bad_n++; $display("FAIL rm_restart_last: got %0d last %b want 0 last 1", got_dig[SLEN-1], got_last[SLEN-1]); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_range();
    test_start_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pi_digit_reader.md
# pi_digit_reader

Display-side consumer of the pi result bus. It latches the `L*N`-bit limb vector produced by the pi calculator. Each limb is a base-1000 value in `N` bits, and limb `L-1` is the integer part. The block converts the limbs MSB-limb-first into a serial stream of 4-bit decimal digits through a valid/ready handshake, for the VGA character renderer. Binary-to-BCD conversion is sequential repeated subtraction, so the block has no dividers.

## Interface
Parameters:
- `L`, default 47: number of limbs.
- `N`, default 10: limb width in bits.
- `PW`, default 9: width of `digit_pos`. Requires `2^PW > 3*L`.

Ports:
- `clk`, in, 1: single clock; all state changes on posedge.
- `rst`, in, 1: **asynchronous, active-low** reset.
- `start`, in, 1: one-cycle request. Honoured only in IDLE.
- `sum`, in, `L*N`: limb vector. Limb `i` is `sum[N*i +: N]`. Sampled only on an accepted `start`.
- `busy`, out, 1: high from the cycle after an accepted `start` until the last digit transfers.
- `digit`, out, 4: BCD digit 0–9. Code `4'hA` is the decimal point.
- `digit_valid`, out, 1: `digit`, `digit_pos` and `digit_last` are valid.
- `digit_ready`, in, 1: sink accepts the digit.
- `digit_last`, out, 1: high with the final digit of the stream.
- `digit_pos`, out, `PW`: index of the current digit in the stream, starting at 0.
- `range_err`, out, 1: sticky error flag. Cleared by reset or by an accepted `start`.

## Operation
- States: IDLE, CONV_H, CONV_T, EMIT_H, EMIT_T, EMIT_U, plus EMIT_DP when `PI_DOT_EN` is defined.
- IDLE: on `start`, latch `sum` into an internal shadow register, set limb index `li = L-1`, clear `range_err` and set pos = 0, then go to CONV_H. `start` is ignored in every other state.
- Limb load, on entry to CONV_H: `r = limb[li]`.
  - If `r > 999`: force `r = 999` and set `range_err`.
  - If `li == L-1` and `r > 9`: force `r = 9` and set `range_err`.
- CONV_H: while `r >= 100`, do `r -= 100` and `h++`, one subtraction per cycle. Otherwise go to CONV_T.
- CONV_T: same procedure with 10 and `t`. Afterwards `u = r`.
- Integer limb (`li == L-1`) emits `u` only, through EMIT_U. With `PI_DOT_EN`, EMIT_DP follows.
- Other limbs emit `h`, then `t`, then `u`, through EMIT_H, EMIT_T and EMIT_U.
- After EMIT_U:
  - If `li != 0`: decrement `li`, clear `h` and `t`, go to CONV_H.
  - If `li == 0`: this was the final digit, with `digit_last = 1`. On transfer go to IDLE.
- Stream length is `1 + 3*(L-1)` digits (139 at defaults), plus one with `PI_DOT_EN` (140).
- `digit_pos` increments by 1 on each transfer.

## Timing
- Reset values: `busy = 0`, `digit = 0`, `digit_valid = 0`, `digit_last = 0`, `digit_pos = 0`, `range_err = 0`. State is IDLE and the shadow register is 0.
- Reset mid-stream aborts immediately. No further valid is issued until a new `start`.
- Transfer occurs on a clock edge where `digit_valid && digit_ready`.
- While `digit_valid && !digit_ready`, `digit`, `digit_pos` and `digit_last` hold stable and `digit_valid` stays high.
- `digit_valid` is high only in EMIT states and never depends combinationally on `digit_ready`.
- Per-limb conversion takes `(h+1) + (t+1)` cycles. The first EMIT state is entered on the edge after CONV_T exits.
- Each EMIT state with `digit_ready` held high lasts exactly 1 cycle.
- `busy` rises on the edge after `start`. It falls on the same edge as the final transfer, when the state returns to IDLE.
- `start` asserted in the cycle `busy` falls is not accepted, because the state is not yet IDLE. `start` is accepted from the following cycle.
- `sum` may change freely after the accepting edge.

## Configuration
- `PI_DOT_EN` defined: after the integer digit, emit `4'hA` at pos 1. Fractional digits then start at pos 2 and `digit_last` is at pos `3*L-2`.
- `PI_DOT_EN` undefined: no decimal-point code is ever emitted. The fractional part starts at pos 1 and `digit_last` is at pos `3*L-3`.

## Test plan
- Basic stream. Setup: limb[46]=3, limb[45]=141, limb[44]=592, limb[43]=653, rest 0, `digit_ready` = 1, `PI_DOT_EN` undefined. Expected: digits 3,1,4,1,5,9,2,6,5,3,0,… with `digit_last` at pos 138 and `busy` falling on that edge.
- Decimal point. Same vector with `PI_DOT_EN` defined. Expected: 3, A, 1, 4, …, with `digit_last` at pos 139.
- Backpressure. Drop `digit_ready` for 5 cycles while pos 2 (digit 4) is presented. Expected: `digit`, `digit_pos` and `digit_valid` hold for all 5 cycles, there are no duplicate or lost digits, and pos 3 = 1.
- Out-of-range limbs. limb[46]=12 and limb[45]=1000. Expected: digits 9,9,9,9 and `range_err` = 1 until the next accepted `start`.
- Start ignored while busy. Pulse `start` with a different `sum` at pos 10. Expected: the stream is unchanged.
- Reset mid-stream. Assert `rst` low asynchronously at pos 20. Expected: all outputs go to 0 immediately. A new `start` restarts from pos 0.
